// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: a single full-adder cell built from two half adders
// processes the operands LSB first over WIDTH cycles, with the carry in a flop.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one operand bit per cycle through the full-adder cell
// DONE  | one-cycle done pulse; sum/cout valid

module serial_add_half (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic             carry, carry_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             half_s, half_c0, half_c1, bit_s;

  serial_add_half u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(half_s), .c(half_c0));
  serial_add_half u_ha1 (.x(half_s),  .y(carry),   .s(bit_s),  .c(half_c1));
  assign carry_nxt = half_c0 | half_c1;

  // New sum bit enters at the MSB so after WIDTH shifts the LSB sits at bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_nxt = bit_s;
    end else begin : g_res_wn
      assign res_nxt = {bit_s, res_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          carry  <= carry_nxt;
          cnt    <= cnt + CNT_W'(1);
          // Publish on the last bit so sum/cout are valid throughout DONE.
          if (last_bit) begin
            sum  <= res_nxt;
            cout <= carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table plus scoreboard queue,
// with hand-written sequences for overlap, abort, back-to-back and WIDTH=1.

module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic busy1, done1, sum1, cout1;

  int total = 0;
  int bad   = 0;

  logic [8:0] sb_q[$];
  logic       mon_on = 1'b0;
  logic [7:0] hold_sum = '0;
  logic       hold_cout = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each done pops one expectation; otherwise results must hold.
  always @(negedge clk) begin
    if (mon_on) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          chk("sb_sum", 32'(sum), 32'(e[7:0]));
          chk("sb_cout", 32'(cout), 32'(e[8]));
          hold_sum  = e[7:0];
          hold_cout = e[8];
        end
      end else begin
        chk("hold_sum", 32'(sum), 32'(hold_sum));
        chk("hold_cout", 32'(cout), 32'(hold_cout));
      end
    end
  end

  task automatic run_add(input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] es, input logic ec);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    sb_q.push_back({ec, es});
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = ~va; b = ~vb;
      end
      chk("run_busy", 32'(busy), 32'(k <= 8));
      chk("run_done", 32'(done), 32'(k == 9));
    end
  endtask

  initial begin
    logic [8:0] full;
    vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    for (int i = 4; i < 8; i++) begin
      vecs[i].a = 8'($urandom_range(255));
      vecs[i].b = 8'($urandom_range(255));
      full = {1'b0, vecs[i].a} + {1'b0, vecs[i].b};
      vecs[i].s = full[7:0];
      vecs[i].c = full[8];
    end

    // Reset and idle hold
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    mon_on = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Vector table
    for (int i = 0; i < 8; i++) run_add(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);

    // Start during RUN is ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    sb_q.push_back({1'b0, 8'h46});
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (k == 3) begin a = 8'hFF; b = 8'hFF; end
      chk("ovl_busy", 32'(busy), 32'(k <= 8));
      chk("ovl_done", 32'(done), 32'(k == 9));
    end

    // Reset mid-RUN aborts
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) begin
        mon_on = 1'b0;
        rst = 1'b1;
      end
      if (k == 5) begin
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
      end
    end
    hold_sum = '0; hold_cout = 1'b0;
    mon_on = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("abort_nodone", 32'(done), 32'd0);
    end
    run_add(8'h01, 8'h01, 8'h02, 1'b0);

    // Continuous start: done every 10 cycles
    @(negedge clk);
    a = 8'h80; b = 8'h80; start = 1'b1;
    for (int it = 0; it < 3; it++) begin
      sb_q.push_back({1'b1, 8'h00});
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        chk("b2b_done", 32'(done), 32'(k == 9));
        if (k == 10 && it == 2) start = 1'b0;
      end
    end
    repeat (12) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    // WIDTH=1 instance: done two cycles after accept
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_busy", 32'(busy1), 32'(k == 1));
      chk("w1_done", 32'(done1), 32'(k == 2));
      if (k == 2) begin
        chk("w1_sum", 32'(sum1), 32'd0);
        chk("w1_cout", 32'(cout1), 32'd1);
      end
    end
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("w1b_done", 32'(done1), 32'd1);
    chk("w1b_sum", 32'(sum1), 32'd1);
    chk("w1b_cout", 32'(cout1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
